// File: rtl/bank_cmd_sched.sv
// ============================================================================
//  Module      : bank_cmd_sched
//  Description : Per-bank ACT/RD/WR/PRE sequencer enforcing tRCD/tRAS/tRP,
//                driving one Bank datapath and returning CAS-delayed reads.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bank_cmd_sched #(
    parameter int DEVICE_WIDTH = 4,
    parameter int COLWIDTH     = 10,
    parameter int CHWIDTH      = 5,
    parameter int TRCD         = 3,
    parameter int TRAS         = 8,
    parameter int TRP          = 3,
    parameter int CL           = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd,
    input  logic [CHWIDTH-1:0]      cmd_row,
    input  logic [COLWIDTH-1:0]     cmd_col,
    input  logic [DEVICE_WIDTH-1:0] cmd_wdata,
    output logic [DEVICE_WIDTH-1:0] rdata,
    output logic                    rdata_valid,
    output logic                    err,
    output logic                    bank_open,
    output logic [CHWIDTH-1:0]      open_row,
    output logic                    bank_rd_o_wr,
    output logic [CHWIDTH-1:0]      bank_row,
    output logic [COLWIDTH-1:0]     bank_col,
    output logic [DEVICE_WIDTH-1:0] bank_dqin,
    input  logic [DEVICE_WIDTH-1:0] bank_dqout
);

    localparam int c_MAX_T = (TRAS > TRP) ? ((TRAS > TRCD) ? TRAS : TRCD)
                                          : ((TRP > TRCD) ? TRP : TRCD);
    localparam int c_CW = $clog2(c_MAX_T + 1);

    localparam logic [c_CW-1:0] c_TRCD_LD = c_CW'(TRCD - 1);
    localparam logic [c_CW-1:0] c_TRAS_LD = c_CW'(TRAS - 1);
    localparam logic [c_CW-1:0] c_TRP_LD  = c_CW'(TRP - 1);
    localparam logic [c_CW-1:0] c_ONE     = c_CW'(1);

    localparam logic [1:0] c_CMD_ACT = 2'b00;
    localparam logic [1:0] c_CMD_RD  = 2'b01;
    localparam logic [1:0] c_CMD_WR  = 2'b10;
    localparam logic [1:0] c_CMD_PRE = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_ACTIVATING  = 2'd1,
        S_ACTIVE      = 2'd2,
        S_PRECHARGING = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [c_CW-1:0]         r_tmr_cnt;
    logic [c_CW-1:0]         r_ras_cnt;
    logic                    w_ras_done;
    logic                    w_acc;
    logic                    w_act_ok;
    logic                    w_rd_ok;
    logic                    w_wr_ok;
    logic                    w_pre_ok;
    logic                    w_illegal;
    logic [CL-1:0]           r_rd_pipe;
    logic [CHWIDTH-1:0]      r_row;
    logic [COLWIDTH-1:0]     r_bank_col;
    logic [DEVICE_WIDTH-1:0] r_bank_dqin;
    logic                    r_bank_wr;
    logic                    r_err;
    logic [DEVICE_WIDTH-1:0] r_rdata;
    logic                    r_rdata_valid;

    assign w_ras_done = (r_ras_cnt == '0);
    assign w_acc      = cmd_valid && cmd_ready;
    assign w_act_ok   = w_acc && (r_state == S_IDLE)   && (cmd == c_CMD_ACT);
    assign w_rd_ok    = w_acc && (r_state == S_ACTIVE) && (cmd == c_CMD_RD);
    assign w_wr_ok    = w_acc && (r_state == S_ACTIVE) && (cmd == c_CMD_WR);
    assign w_pre_ok   = w_acc && (r_state == S_ACTIVE) && (cmd == c_CMD_PRE);
    assign w_illegal  = w_acc && (((r_state == S_IDLE)   && (cmd != c_CMD_ACT)) ||
                                  ((r_state == S_ACTIVE) && (cmd == c_CMD_ACT)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Accept is decided from cmd_valid directly so the ready path stays acyclic.
    always_comb begin
        w_state_nxt = r_state;
        cmd_ready   = 1'b0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid && (cmd == c_CMD_ACT)) begin
                    w_state_nxt = (TRCD == 1) ? S_ACTIVE : S_ACTIVATING;
                end
            end
            S_ACTIVATING: begin
                if (r_tmr_cnt <= c_ONE) begin
                    w_state_nxt = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                cmd_ready = !((cmd == c_CMD_PRE) && !w_ras_done);
                if (cmd_valid && (cmd == c_CMD_PRE) && w_ras_done) begin
                    w_state_nxt = (TRP == 1) ? S_IDLE : S_PRECHARGING;
                end
            end
            S_PRECHARGING: begin
                if (r_tmr_cnt <= c_ONE) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (rst) begin
            cmd_ready   = 1'b0;
            w_state_nxt = S_IDLE;
        end
    end

    // tRCD and tRP never overlap, so they share one timer; tRAS runs alongside.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmr_cnt <= '0;
            r_ras_cnt <= '0;
        end else begin
            if (w_act_ok) begin
                r_tmr_cnt <= c_TRCD_LD;
            end else if (w_pre_ok) begin
                r_tmr_cnt <= c_TRP_LD;
            end else if (r_tmr_cnt != '0) begin
                r_tmr_cnt <= r_tmr_cnt - c_ONE;
            end

            if (w_act_ok) begin
                r_ras_cnt <= c_TRAS_LD;
            end else if (r_ras_cnt != '0) begin
                r_ras_cnt <= r_ras_cnt - c_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_row         <= '0;
            r_bank_col    <= '0;
            r_bank_dqin   <= '0;
            r_bank_wr     <= 1'b0;
            r_err         <= 1'b0;
            r_rd_pipe     <= '0;
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
        end else begin
            r_err       <= w_illegal;
            r_bank_wr   <= w_wr_ok;
            r_bank_dqin <= w_wr_ok ? cmd_wdata : '0;
            if (w_rd_ok || w_wr_ok) begin
                r_bank_col <= cmd_col;
            end
            if (w_act_ok) begin
                r_row <= cmd_row;
            end else if (w_pre_ok) begin
                r_row <= '0;
            end
            // Stage CL-1 is live during cycle t+CL, when bank_dqout holds the read.
            r_rd_pipe[0] <= w_rd_ok;
            for (int i = 1; i < CL; i++) begin
                r_rd_pipe[i] <= r_rd_pipe[i-1];
            end
            r_rdata_valid <= r_rd_pipe[CL-1];
            r_rdata       <= r_rd_pipe[CL-1] ? bank_dqout : '0;
        end
    end

    assign bank_open    = (r_state == S_ACTIVE);
    assign open_row     = r_row;
    assign bank_row     = r_row;
    assign bank_col     = r_bank_col;
    assign bank_dqin    = r_bank_dqin;
    assign bank_rd_o_wr = r_bank_wr;
    assign err          = r_err;
    assign rdata        = r_rdata;
    assign rdata_valid  = r_rdata_valid;

endmodule

`default_nettype wire

// File: tb/tb_bank_cmd_sched.sv
// ============================================================================
//  Module      : tb_bank_cmd_sched
//  Description : Scoreboarded bench for bank_cmd_sched with a timing-rule
//                reference model and a registered Bank memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bank_cmd_sched;

    localparam int DW   = 4;
    localparam int CW   = 10;
    localparam int RW   = 5;
    localparam int TRCD = 3;
    localparam int TRAS = 8;
    localparam int TRP  = 3;
    localparam int CL   = 2;

    localparam logic [1:0] c_ACT = 2'b00;
    localparam logic [1:0] c_RD  = 2'b01;
    localparam logic [1:0] c_WR  = 2'b10;
    localparam logic [1:0] c_PRE = 2'b11;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd = 2'b00;
    logic [RW-1:0] cmd_row = '0;
    logic [CW-1:0] cmd_col = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [DW-1:0] rdata;
    logic          rdata_valid;
    logic          err;
    logic          bank_open;
    logic [RW-1:0] open_row;
    logic          bank_rd_o_wr;
    logic [RW-1:0] bank_row;
    logic [CW-1:0] bank_col;
    logic [DW-1:0] bank_dqin;
    logic [DW-1:0] bank_dqout;

    bank_cmd_sched #(
        .DEVICE_WIDTH(DW), .COLWIDTH(CW), .CHWIDTH(RW),
        .TRCD(TRCD), .TRAS(TRAS), .TRP(TRP), .CL(CL)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd(cmd), .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_wdata(cmd_wdata),
        .rdata(rdata), .rdata_valid(rdata_valid), .err(err),
        .bank_open(bank_open), .open_row(open_row),
        .bank_rd_o_wr(bank_rd_o_wr), .bank_row(bank_row), .bank_col(bank_col),
        .bank_dqin(bank_dqin), .bank_dqout(bank_dqout)
    );

    always #5 clk = ~clk;

    // Bank model: registered address, so dqout reflects the column one cycle later.
    logic [DW-1:0] bank_mem [0:(1<<(RW+CW))-1];
    logic [RW-1:0] bm_row;
    logic [CW-1:0] bm_col;
    always @(posedge clk) begin
        bm_row <= bank_row;
        bm_col <= bank_col;
        if (bank_rd_o_wr) bank_mem[{bank_row, bank_col}] <= bank_dqin;
    end
    assign bank_dqout = bank_mem[{bm_row, bm_col}];

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [DW-1:0] data;
        bit            known;
        int            cyc;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    // Reference model state: bank open flag, row, and the cycles of the last ACT/PRE.
    bit            m_open = 1'b0;
    logic [RW-1:0] m_row  = '0;
    int            m_act  = -1000;
    int            m_pre  = -1000;
    bit            m_err  = 1'b0;
    bit            m_wr   = 1'b0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] ref_mem [int];
    bit            last_acc = 1'b0;
    int            last_acc_cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h want=%0h cycle=%0d", nm, act, exp, cyc_cnt);
        end
    endtask

    function automatic bit exp_ready(input int c, input logic [1:0] k);
        if (!m_open) return (c >= m_pre + TRP);
        if (c < m_act + TRCD) return 1'b0;
        if ((k == c_PRE) && (c < m_act + TRAS)) return 1'b0;
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc < cyc_cnt) begin
            checks++;
            failures++;
            $display("FAIL rdata_missing: got=none want=valid@%0d cycle=%0d", sb_q[0].cyc, cyc_cnt);
            void'(sb_q.pop_front());
        end
        if (rdata_valid) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL rdata_unexpected: got=valid data=%0h want=none cycle=%0d", rdata, cyc_cnt);
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_e.cyc != cyc_cnt || (mon_e.known && rdata !== mon_e.data)) begin
                    failures++;
                    $display("FAIL rdata: got=%0h@%0d want=%0h@%0d", rdata, cyc_cnt, mon_e.data, mon_e.cyc);
                end
            end
        end
    end

    task automatic step();
        bit er;
        int c;
        int key;
        @(negedge clk);
        c  = cyc_cnt;
        er = exp_ready(c, cmd);
        chk("cmd_ready", 32'(cmd_ready), 32'(er));
        chk("err", 32'(err), 32'(m_err));
        chk("bank_open", 32'(bank_open), 32'(m_open && (c >= m_act + TRCD)));
        chk("open_row", 32'(open_row), 32'(m_open ? m_row : 5'd0));
        chk("bank_row", 32'(bank_row), 32'(m_open ? m_row : 5'd0));
        chk("bank_wr", 32'({bank_rd_o_wr, bank_dqin}), 32'({m_wr, (m_wr ? m_wdata : 4'h0)}));
        m_err    = 1'b0;
        m_wr     = 1'b0;
        last_acc = cmd_valid && er;
        if (last_acc) begin
            last_acc_cyc = c;
            key = int'({m_row, cmd_col});
            case (cmd)
                c_ACT: if (m_open) m_err = 1'b1;
                       else begin m_open = 1'b1; m_row = cmd_row; m_act = c; end
                c_RD:  if (!m_open) m_err = 1'b1;
                       else sb_q.push_back('{ref_mem.exists(key) ? ref_mem[key] : 4'h0,
                                              ref_mem.exists(key), c + CL + 1});
                c_WR:  if (!m_open) m_err = 1'b1;
                       else begin ref_mem[key] = cmd_wdata; m_wr = 1'b1; m_wdata = cmd_wdata; end
                default: if (!m_open) m_err = 1'b1;
                         else begin m_open = 1'b0; m_pre = c; end
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        cmd_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic issue(input logic [1:0] k, input logic [RW-1:0] row,
                         input logic [CW-1:0] col, input logic [DW-1:0] wd,
                         output int acc_c);
        cmd_valid = 1'b1; cmd = k; cmd_row = row; cmd_col = col; cmd_wdata = wd;
        acc_c = -1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (last_acc) begin
                acc_c = last_acc_cyc;
                break;
            end
        end
        cmd_valid = 1'b0;
        if (acc_c < 0) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got=no_accept want=accept cmd=%0d cycle=%0d", k, cyc_cnt);
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        cmd_valid = 1'b0;
        sb_q.delete();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("ready_in_rst", 32'(cmd_ready), 32'd0);
            if (i > 0)
                chk("outputs_in_rst", {rdata, rdata_valid, err, bank_open, open_row,
                                       bank_rd_o_wr, bank_row, bank_col, bank_dqin}, 32'd0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        m_open = 1'b0; m_pre = -1000; m_act = -1000; m_err = 1'b0; m_wr = 1'b0;
    endtask

    int t_act, t_rd, t_pre, t_act2, t_tmp;
    int r;
    logic [1:0] k;

    initial begin
        do_reset(3);

        // Activate timing: RD held valid behind an ACT.
        issue(c_ACT, 5'd1, '0, '0, t_act);
        issue(c_RD, '0, 10'd0, '0, t_rd);
        chk("trcd_accept", 32'(t_rd - t_act), 32'(TRCD));
        idle(4);

        // Write then read back eight columns, back-to-back.
        for (int i = 0; i < 8; i++) issue(c_WR, '0, 10'(i), 4'($urandom), t_tmp);
        for (int i = 0; i < 8; i++) issue(c_RD, '0, 10'(i), '0, t_tmp);
        idle(6);

        // tRAS / tRP: PRE offered 4 cycles after ACT, then ACT offered right after.
        issue(c_PRE, '0, '0, '0, t_tmp);
        issue(c_ACT, 5'd6, '0, '0, t_act);
        idle(3);
        issue(c_PRE, '0, '0, '0, t_pre);
        chk("tras_accept", 32'(t_pre - t_act), 32'(TRAS));
        issue(c_ACT, 5'd9, '0, '0, t_act2);
        chk("trp_accept", 32'(t_act2 - t_pre), 32'(TRP));

        // Illegal commands: ACT while ACTIVE, then RD in IDLE.
        idle(3);
        issue(c_ACT, 5'd17, '0, '0, t_tmp);
        idle(2);
        issue(c_PRE, '0, '0, '0, t_tmp);
        idle(3);
        issue(c_RD, '0, 10'd3, '0, t_tmp);
        idle(4);

        // Reset with a read in flight.
        issue(c_ACT, 5'd2, '0, '0, t_tmp);
        issue(c_RD, '0, 10'd1, '0, t_tmp);
        do_reset(3);
        idle(6);

        // Randomized traffic, mostly legal, over a small address window.
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            if (m_open) k = (r < 45) ? c_RD : (r < 85) ? c_WR : (r < 96) ? c_PRE : c_ACT;
            else        k = (r < 85) ? c_ACT : 2'($urandom_range(1, 3));
            cmd_valid = ($urandom_range(0, 3) != 0);
            cmd       = k;
            cmd_row   = 5'($urandom_range(0, 3));
            cmd_col   = 10'($urandom_range(0, 7));
            cmd_wdata = 4'($urandom);
            step();
        end
        idle(8);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bank_cmd_sched.md
Name: bank_cmd_sched

Overview:
- Per-bank command controller that sequences one Bank datapath instance (row/column/rd_o_wr/dqin/dqout).
- Accepts ACT/RD/WR/PRE commands over a valid/ready handshake and enforces tRCD, tRAS and tRP.
- Drives the Bank's registered address and data inputs, and returns read data after a fixed CAS latency.
- Sits between the channel-level scheduler and each Bank in the DRAM device model.

Parameters:
- DEVICE_WIDTH, 4, data width of the Bank dq path.
- COLWIDTH, 10, column address width.
- CHWIDTH, 5, row address width (matches the Bank's row port).
- TRCD, 3, minimum cycles from ACT accept to RD/WR accept (must be >=1).
- TRAS, 8, minimum cycles from ACT accept to PRE accept (must be >=TRCD).
- TRP, 3, minimum cycles from PRE accept to next ACT accept (must be >=1).
- CL, 2, read latency in cycles after the Bank column is presented (must be >=1).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accept; a transfer occurs when cmd_valid && cmd_ready.
- cmd  in  2  command: 00 ACT, 01 RD, 10 WR, 11 PRE.
- cmd_row  in  CHWIDTH  row address, used by ACT.
- cmd_col  in  COLWIDTH  column address, used by RD/WR.
- cmd_wdata  in  DEVICE_WIDTH  write data, used by WR.
- rdata  out  DEVICE_WIDTH  read return data.
- rdata_valid  out  1  one-cycle pulse per RD.
- err  out  1  one-cycle pulse when an illegal command is accepted.
- bank_open  out  1  state is ACTIVE.
- open_row  out  CHWIDTH  currently open row; 0 when closed.
- bank_rd_o_wr  out  1  to Bank: 1 = write, 0 = read.
- bank_row  out  CHWIDTH  to Bank row.
- bank_col  out  COLWIDTH  to Bank column.
- bank_dqin  out  DEVICE_WIDTH  to Bank dqin.
- bank_dqout  in  DEVICE_WIDTH  from Bank dqout.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE; all counters cleared; read pipeline flushed.
  - All outputs are 0 in the cycle after the reset edge: cmd_ready=0 while rst is high, and cmd_ready=1 thereafter in IDLE.
  - A reset mid-operation discards any in-flight RD; no rdata_valid may follow a reset.
- States:
  - IDLE (precharged).
  - ACTIVATING (tRCD countdown).
  - ACTIVE.
  - PRECHARGING (tRP countdown).
- Cycle numbering: the cycle in which a command is accepted is cycle t.
- ACT in IDLE:
  - Latch cmd_row into open_row and bank_row.
  - Go to ACTIVATING.
  - RD/WR become acceptable from cycle t+TRCD (state ACTIVE, bank_open=1).
  - PRE becomes acceptable from cycle t+TRAS.
- cmd_ready:
  - 0 in ACTIVATING and PRECHARGING.
  - 0 in ACTIVE when cmd==PRE and tRAS has not elapsed.
  - 1 otherwise. It is combinational on state, counters and cmd.
- WR in ACTIVE: during cycle t+1 drive bank_rd_o_wr=1, bank_col=cmd_col, bank_dqin=cmd_wdata; then revert to bank_rd_o_wr=0 and bank_dqin=0 unless another WR follows.
- RD in ACTIVE:
  - During cycle t+1 drive bank_rd_o_wr=0 and bank_col=cmd_col.
  - Sample bank_dqout at the edge ending cycle t+CL.
  - rdata_valid=1 with that data in cycle t+CL+1.
- Read pipeline: a CL-deep shift of valid bits. Back-to-back RDs (one per cycle) return one per cycle, in order. RD/WR may be interleaved freely.
- PRE in ACTIVE (after tRAS):
  - Go to PRECHARGING.
  - bank_row, open_row and bank_open go to 0 in cycle t+1.
  - The next ACT is acceptable from cycle t+TRP.
  - Reads already issued still complete.
- Illegal commands are accepted (cmd_ready=1) and ignored, with err=1 in cycle t+1. Illegal means:
  - RD, WR or PRE while in IDLE.
  - ACT while ACTIVE.
- Counters: each is a saturating down-counter of width $clog2(max(TRAS,TRP,TRCD)+1). No wrap-around is permitted.
- No commands are queued; holding cmd_valid while cmd_ready=0 stalls the requester. Inputs are sampled only on accept.

Test Plan:
- Reset: hold rst for 3 cycles -> all outputs 0; cmd_ready=1 in the first cycle after rst deasserts.
- Activate timing: ACT row=1 at t=0, then RD col=0 held valid -> cmd_ready=0 in cycles 1-2, RD accepted in cycle 3, bank_row=1 from cycle 1.
- Write/read-back: ACT row=1, then WR cols 0..7 with $random data back-to-back, then RD cols 0..7 back-to-back -> 8 consecutive rdata_valid pulses starting CL+1 cycles after the first RD accept, data matching writes in order.
- tRAS/tRP: PRE presented at cycle 4 after ACT -> stalled until cycle 8. ACT presented immediately after -> accepted at PRE+3. open_row=0 between the two.
- Illegal: RD in IDLE -> accepted, err pulse one cycle, no rdata_valid. ACT while ACTIVE -> err, open_row unchanged.
- Reset mid-read: RD accepted, rst asserted next cycle -> rdata_valid never asserts, state IDLE, bank_open=0.
